alu_mext_pipe: RTL and testbench

- Parametrised, registered successor to the execute-stage ALU.
- Adds a valid/ready handshake on input and output and a registered result stage.
- Adds optional RV32M support: single-cycle multiply and an iterative N-cycle divider/remainder unit.
- Sits between the decode/execute and execute/memory pipeline registers; it can back-pressure decode while a divide is in flight.

---
 rtl/alu_mext_pipe.sv | 273 +++++++++++++++++++++++++++
 tb/tb_alu_mext_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mext_pipe.sv
// alu_mext_pipe: registered execute-stage ALU with valid/ready handshakes,
// base RV32I integer ops, and optional RV32M multiply plus an iterative
// restoring divider that back-pressures the issue side while it runs.
module alu_mext_pipe #(
   parameter int N        = 32,
   parameter bit ENABLE_M = 1'b1,
   parameter int SHAMT_W  = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [4:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         zero,
   output logic         illegal,
   output logic         busy
);

   localparam int            CNT_W   = $clog2(N);
   localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};

   typedef enum logic {S_IDLE, S_DIV} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_out_valid;
   logic [N-1:0]       r_result;
   logic               r_zero;
   logic               r_illegal;

   // Divider working registers: dividend shifts out of r_quo while
   // quotient bits shift in; r_rem holds the partial remainder.
   logic [N-1:0]       r_quo;
   logic [N-1:0]       r_rem;
   logic [N-1:0]       r_dvsr;
   logic               r_neg_out;
   logic               r_want_rem;

   logic               w_m;
   logic               w_alt;
   logic [2:0]         w_f3;
   logic [SHAMT_W-1:0] w_shamt;
   logic               w_accept;

   assign w_m     = op[4];
   assign w_alt   = op[3];
   assign w_f3    = op[2:0];
   assign w_shamt = b[SHAMT_W-1:0];

   // A new op is taken only when the divider is idle and the result slot
   // is free or being drained this cycle; never a function of in_valid.
   assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // ------------------------------------------------------------------
   // Base integer ops
   // ------------------------------------------------------------------
   logic [N-1:0] w_base_res;
   logic         w_base_ill;

   // Base ALU result; alt is only meaningful for ADD/SUB and SRL/SRA.
   // NOTE: every output of a combinational block gets a default first so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_base_res = '0;
      w_base_ill = 1'b0;
      case (w_f3)
         3'd0: w_base_res = w_alt ? (a - b) : (a + b);
         3'd1: w_base_res = a << w_shamt;
         3'd2: w_base_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
         3'd3: w_base_res = {{(N-1){1'b0}}, (a < b)};
         3'd4: w_base_res = a ^ b;
         3'd5: begin
            // Kept as separate statements: a ternary mixing the signed and
            // unsigned shift would turn the arithmetic shift logical.
            if (w_alt) w_base_res = $signed(a) >>> w_shamt;
            else       w_base_res = a >> w_shamt;
         end
         3'd6: w_base_res = a | b;
         default: w_base_res = a & b;
      endcase
      if (w_alt && (w_f3 != 3'd0) && (w_f3 != 3'd5)) begin
         w_base_ill = 1'b1;
         w_base_res = '0;
      end
   end

   // ------------------------------------------------------------------
   // Multiplier: one 2N-bit product, operands pre-extended per signedness
   // ------------------------------------------------------------------
   logic [N-1:0] w_mul_res;

   if (ENABLE_M) begin : g_mul
      logic         w_sext_a;
      logic         w_sext_b;
      logic [2*N-1:0] w_ma;
      logic [2*N-1:0] w_mb;
      logic [2*N-1:0] w_prod;

      assign w_sext_a  = ((w_f3 == 3'd1) || (w_f3 == 3'd2)) && a[N-1];
      assign w_sext_b  = (w_f3 == 3'd1) && b[N-1];
      assign w_ma      = {{N{w_sext_a}}, a};
      assign w_mb      = {{N{w_sext_b}}, b};
      assign w_prod    = w_ma * w_mb;
      assign w_mul_res = (w_f3 == 3'd0) ? w_prod[N-1:0] : w_prod[2*N-1:N];
   end else begin : g_no_mul
      assign w_mul_res = '0;
   end

   // ------------------------------------------------------------------
   // Divide decode, special cases and operand magnitudes
   // ------------------------------------------------------------------
   logic         w_is_div;
   logic         w_div_signed;
   logic         w_div_rem;
   logic         w_b_zero;
   logic         w_ovf;
   logic         w_div_special;
   logic [N-1:0] w_div_special_res;
   logic         w_div_start;
   logic         w_a_neg;
   logic         w_b_neg;
   logic [N-1:0] w_a_mag;
   logic [N-1:0] w_b_mag;

   assign w_is_div      = ENABLE_M && w_m && !w_alt && w_f3[2];
   assign w_div_signed  = !w_f3[0];
   assign w_div_rem     = w_f3[1];
   assign w_b_zero      = (b == '0);
   assign w_ovf         = w_div_signed && (a == MIN_NEG) && (b == '1);
   assign w_div_special = w_b_zero || w_ovf;
   assign w_div_start   = w_accept && w_is_div && !w_div_special;

   // Divide by zero and signed overflow resolve immediately.
   always_comb begin
      w_div_special_res = '0;
      if (w_b_zero)
         w_div_special_res = w_div_rem ? a : '1;
      else if (w_ovf)
         w_div_special_res = w_div_rem ? '0 : a;
   end

   assign w_a_neg = w_div_signed && a[N-1];
   assign w_b_neg = w_div_signed && b[N-1];
   assign w_a_mag = w_a_neg ? (-a) : a;
   assign w_b_mag = w_b_neg ? (-b) : b;

   // ------------------------------------------------------------------
   // Single-cycle result select
   // ------------------------------------------------------------------
   logic [N-1:0] w_res;
   logic         w_ill;

   // Merge base, multiply and divide-special results; illegal forces 0.
   always_comb begin
      w_res = '0;
      w_ill = 1'b0;
      if (!w_m) begin
         w_res = w_base_res;
         w_ill = w_base_ill;
      end else if (w_alt || !ENABLE_M) begin
         w_ill = 1'b1;
      end else if (!w_f3[2]) begin
         w_res = w_mul_res;
      end else begin
         w_res = w_div_special_res;
      end
   end

   // ------------------------------------------------------------------
   // Restoring divide step
   // ------------------------------------------------------------------
   logic [N:0]   w_shift;
   logic         w_fits;
   logic [N-1:0] w_sub;
   logic [N-1:0] w_quo_next;
   logic [N-1:0] w_rem_next;
   logic [N-1:0] w_div_final;
   logic         w_last;

   assign w_shift    = {r_rem, r_quo[N-1]};
   assign w_fits     = (w_shift >= {1'b0, r_dvsr});
   // When the divisor fits the difference is below 2^N, so N bits suffice.
   assign w_sub      = w_shift[N-1:0] - r_dvsr;
   assign w_quo_next = {r_quo[N-2:0], w_fits};
   assign w_rem_next = w_fits ? w_sub : w_shift[N-1:0];
   assign w_last     = (r_state == S_DIV) && (r_cnt == CNT_W'(N-1));

   // Sign correction applied on the final step's quotient or remainder.
   always_comb begin
      w_div_final = '0;
      if (r_want_rem)
         w_div_final = r_neg_out ? (-w_rem_next) : w_rem_next;
      else
         w_div_final = r_neg_out ? (-w_quo_next) : w_quo_next;
   end

   // Divider control FSM: IDLE -> DIV for N steps -> IDLE.
   // NOTE: sequential state is always written with non-blocking assignments
   // so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_div_start) r_state <= S_DIV;
            end
            default: begin
               if (w_last) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Divider datapath: load magnitudes on start, one step per DIV cycle.
   // NOTE: these registers carry no reset; they are always loaded on
   // divide start before use, and the FSM reset alone discards a divide.
   always_ff @(posedge clk) begin
      if (w_div_start) begin
         r_quo      <= w_a_mag;
         r_rem      <= '0;
         r_dvsr     <= w_b_mag;
         r_want_rem <= w_div_rem;
         r_neg_out  <= w_div_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
      end else if (r_state == S_DIV) begin
         r_quo <= w_quo_next;
         r_rem <= w_rem_next;
      end
   end

   // Output register: load on single-cycle accept or divide completion,
   // hold while stalled, drop valid once consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_illegal   <= 1'b0;
      end else if (w_accept && !w_div_start) begin
         r_out_valid <= 1'b1;
         r_result    <= w_res;
         r_zero      <= (w_res == '0);
         r_illegal   <= w_ill;
      end else if (w_last) begin
         r_out_valid <= 1'b1;
         r_result    <= w_div_final;
         r_zero      <= (w_div_final == '0);
         r_illegal   <= 1'b0;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign illegal   = r_illegal;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_mext_pipe.sv
// Self-checking bench for alu_mext_pipe: directed test-plan cases, then
// randomized traffic with random back-pressure against an arithmetic model.
module tb_alu_mext_pipe;

   localparam int N = 32;

   localparam logic [4:0] OP_ADD    = 5'b00000;
   localparam logic [4:0] OP_SUB    = 5'b01000;
   localparam logic [4:0] OP_SRL    = 5'b00101;
   localparam logic [4:0] OP_SRA    = 5'b01101;
   localparam logic [4:0] OP_MUL    = 5'b10000;
   localparam logic [4:0] OP_MULH   = 5'b10001;
   localparam logic [4:0] OP_MULHSU = 5'b10010;
   localparam logic [4:0] OP_MULHU  = 5'b10011;
   localparam logic [4:0] OP_DIV    = 5'b10100;
   localparam logic [4:0] OP_DIVU   = 5'b10101;
   localparam logic [4:0] OP_REM    = 5'b10110;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [4:0]   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         zero;
   logic         illegal;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   logic [32:0] exp_q[$];
   logic [32:0] exp_e;
   logic        hold_prev = 1'b0;
   logic [33:0] held;

   always #5 clk = ~clk;

   alu_mext_pipe #(.N(N), .ENABLE_M(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal),
      .busy      (busy)
   );

   // Reference: {illegal, result} from the RISC-V rules using 64-bit math.
   function automatic logic [32:0] model(input logic [4:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
      logic        m   = o[4];
      logic        alt = o[3];
      logic [2:0]  f   = o[2:0];
      longint      sx  = longint'($signed(x));
      longint      sy  = longint'($signed(y));
      logic [63:0] ux  = {32'h0, x};
      logic [63:0] uy  = {32'h0, y};
      logic [63:0] p;
      int          sh  = int'(y[4:0]);
      logic [31:0] r   = 32'h0;
      logic        ill = 1'b0;
      logic        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      if (!m) begin
         case (f)
            3'd0: r = alt ? x - y : x + y;
            3'd1: r = x << sh;
            3'd2: r = (sx < sy) ? 32'd1 : 32'd0;
            3'd3: r = (x < y) ? 32'd1 : 32'd0;
            3'd4: r = x ^ y;
            3'd5: begin
               p = 64'(sx >>> sh);
               r = alt ? p[31:0] : x >> sh;
            end
            3'd6: r = x | y;
            default: r = x & y;
         endcase
         if (alt && f != 3'd0 && f != 3'd5) ill = 1'b1;
      end else if (alt) begin
         ill = 1'b1;
      end else begin
         case (f)
            3'd0: begin p = 64'(sx * sy);              r = p[31:0];  end
            3'd1: begin p = 64'(sx * sy);              r = p[63:32]; end
            3'd2: begin p = 64'(sx * longint'(uy));    r = p[63:32]; end
            3'd3: begin p = ux * uy;                   r = p[63:32]; end
            3'd4: begin
               p = 64'(sx / ((y == 0) ? 64'sd1 : sy));
               r = (y == 0) ? 32'hFFFF_FFFF : ovf ? x : p[31:0];
            end
            3'd5: begin
               p = ux / ((y == 0) ? 64'd1 : uy);
               r = (y == 0) ? 32'hFFFF_FFFF : p[31:0];
            end
            3'd6: begin
               p = 64'(sx % ((y == 0) ? 64'sd1 : sy));
               r = (y == 0) ? x : ovf ? 32'h0 : p[31:0];
            end
            default: begin
               p = ux % ((y == 0) ? 64'd1 : uy);
               r = (y == 0) ? x : p[31:0];
            end
         endcase
      end
      if (ill) r = 32'h0;
      return {ill, r};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Record expected result for every accepted op; reset flushes them.
   always @(posedge clk) begin
      if (rst)
         exp_q.delete();
      else if (in_valid && in_ready)
         exp_q.push_back(model(op, a, b));
   end

   // Compare process: scoreboard on output transfers, stall stability,
   // and no issue while the divider is busy.
   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev)
            check("hold_stable", {out_valid, illegal, zero, result}, {1'b1, held});
         if (busy)
            check("busy_blocks_input", in_ready, 0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: result 0x%0h with no pending op", result);
            end else begin
               exp_e = exp_q.pop_front();
               check("sb_result", {illegal, zero, result},
                     {exp_e[32], exp_e[31:0] == 32'h0, exp_e[31:0]});
            end
         end
         hold_prev = out_valid && !out_ready;
         held      = {illegal, zero, result};
      end
   end

   // Present an op and wait (bounded) until it is accepted.
   task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      bit took = 1'b0;
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      for (int i = 0; i < 100 && !took; i++) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!took) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: op 0x%0h not accepted within 100 cycles", o);
      end
   endtask

   // Single-cycle op: result must be valid on the cycle after accept.
   task automatic single(input string name, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input logic ei);
      issue(o, x, y);
      @(negedge clk);
      check({name, "_valid"}, out_valid, 1);
      check({name, "_result"}, {illegal, zero, result}, {ei, er == 32'h0, er});
      @(posedge clk);
      #1;
   endtask

   // Iterative divide: busy for N cycles, valid N+1 cycles after accept.
   task automatic div_op(input string name, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er);
      int cyc    = 1;
      int busy_n = 0;
      bit rdy    = 1'b0;
      issue(o, x, y);
      @(negedge clk);
      while (!out_valid && cyc < 100) begin
         busy_n += int'(busy);
         rdy |= in_ready;
         cyc++;
         @(negedge clk);
      end
      check({name, "_latency"}, cyc, N + 1);
      check({name, "_busy_cycles"}, busy_n, N);
      check({name, "_in_ready_seen"}, rdy, 0);
      check({name, "_result"}, {illegal, zero, result}, {1'b0, er == 32'h0, er});
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit pending;
      bit took;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_zero", zero, 0);
      check("rst_illegal", illegal, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);

      // Pin the model against hand-computed values
      check("model_sra", model(OP_SRA, 32'h8000_0010, 32'h24), {1'b0, 32'hF800_0001});
      check("model_mulhu", model(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 32'hFFFF_FFFE});
      check("model_mulhsu", model(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 32'hFFFF_FFFF});
      check("model_div", model(OP_DIV, 32'hFFFF_FFF9, 32'd2), {1'b0, 32'hFFFF_FFFD});
      check("model_rem", model(OP_REM, 32'hFFFF_FFF9, 32'd2), {1'b0, 32'hFFFF_FFFF});
      check("model_illegal", model(5'b01001, 32'd1, 32'd1), {1'b1, 32'h0});
      @(posedge clk);
      #1;

      // Back-to-back ADD then SUB at full throughput
      in_valid = 1'b1; op = OP_ADD; a = 32'h7FFF_FFFF; b = 32'd1;
      @(negedge clk);
      check("b2b_in_ready0", in_ready, 1);
      @(posedge clk);
      #1 op = OP_SUB; a = 32'd5; b = 32'd5;
      @(negedge clk);
      check("b2b_in_ready1", in_ready, 1);
      check("b2b_add", {out_valid, zero, result}, {1'b1, 1'b0, 32'h8000_0000});
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("b2b_sub", {out_valid, zero, result}, {1'b1, 1'b1, 32'h0});
      @(posedge clk);
      #1;

      // Shifts, multiplies, divide specials, illegal ops
      single("sra", OP_SRA, 32'h8000_0010, 32'h24, 32'hF800_0001, 1'b0);
      single("srl", OP_SRL, 32'h8000_0010, 32'h24, 32'h0800_0001, 1'b0);
      single("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
      single("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      single("mul", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0);
      single("divu_by0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0);
      single("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
      single("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      single("ill_base", 5'b01001, 32'd3, 32'd4, 32'h0, 1'b1);
      single("ill_m_alt", 5'b11000, 32'd3, 32'd4, 32'h0, 1'b1);

      // Iterative divides
      div_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      div_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

      // Stall: result held, no new ops accepted
      out_ready = 1'b0;
      issue(OP_ADD, 32'd3, 32'd4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_result", {out_valid, result}, {1'b1, 32'd7});
         check("stall_in_ready", in_ready, 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset in the middle of a divide
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_result", result, 0);
      @(posedge clk);
      #1;
      single("post_rst_add", OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0);

      // Randomized traffic with random back-pressure
      pending = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!pending && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            op       = 5'($urandom_range(0, 31));
            a        = pick_val();
            b        = pick_val();
            pending  = 1'b1;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (took) begin
            in_valid = 1'b0;
            pending  = 1'b0;
         end
      end

      // Drain
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      check("drain_empty", exp_q.size(), 0);
      check("drain_out_valid", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
